// File: rtl/serial_to_parallel.sv
// Serial-to-parallel SRAM write bridge: shifts in a 20-bit address and 16-bit data word
// LSB first, then runs a single SETUP / WRITE x2 / HOLD write cycle on the parallel bus.
module serial_to_parallel (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_en,
    input  logic        addr_in,
    input  logic        data_in,
    output logic [19:0] addr_out,
    output logic [15:0] data_out,
    output logic        chip_en,
    output logic        write_en,
    output logic        out_en,
    output logic        lower_byte_en,
    output logic        upper_byte_en
);

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 5;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_W);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SHIFT    = 3'd1;
    localparam logic [2:0] SETUP    = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;
    localparam logic [2:0] WAIT_LOW = 3'd5;

    logic [2:0]        state, state_next;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
    logic              wr_cnt, wr_cnt_next;
    logic [ADDR_W-1:0] addr_sr, addr_sr_next, addr_out_next;
    logic [DATA_W-1:0] data_sr, data_sr_next, data_out_next;
    logic              mem_sel_c, write_sel_c;

    // State register plus registered outputs decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            wr_cnt        <= 1'b0;
            addr_sr       <= '0;
            data_sr       <= '0;
            addr_out      <= '0;
            data_out      <= '0;
            chip_en       <= 1'b1;
            write_en      <= 1'b1;
            out_en        <= 1'b1;
            lower_byte_en <= 1'b1;
            upper_byte_en <= 1'b1;
        end else begin
            state         <= state_next;
            bit_cnt       <= bit_cnt_next;
            wr_cnt        <= wr_cnt_next;
            addr_sr       <= addr_sr_next;
            data_sr       <= data_sr_next;
            addr_out      <= addr_out_next;
            data_out      <= data_out_next;
            chip_en       <= ~mem_sel_c;
            write_en      <= ~write_sel_c;
            out_en        <= 1'b1;
            lower_byte_en <= ~mem_sel_c;
            upper_byte_en <= ~mem_sel_c;
        end
    end

    // Next-state, shift and output-load logic
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        wr_cnt_next   = wr_cnt;
        addr_sr_next  = addr_sr;
        data_sr_next  = data_sr;
        addr_out_next = addr_out;
        data_out_next = data_out;

        case (state)
            IDLE: begin
                if (ctrl_en) begin
                    addr_sr_next[0] = addr_in;
                    data_sr_next[0] = data_in;
                    bit_cnt_next    = CNT_W'(1);
                    state_next      = SHIFT;
                end
            end
            SHIFT: begin
                if (!ctrl_en) begin
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    addr_sr_next[bit_cnt] = addr_in;
                    if (bit_cnt < DATA_BITS) begin
                        data_sr_next[bit_cnt[3:0]] = data_in;
                    end
                    if (bit_cnt == LAST_BIT) begin
                        // Final address bit arrives this edge, so load the merged word
                        addr_out_next = addr_sr_next;
                        data_out_next = data_sr;
                        state_next    = SETUP;
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
            end
            SETUP: begin
                wr_cnt_next = 1'b0;
                state_next  = WRITE;
            end
            WRITE: begin
                if (wr_cnt) begin
                    state_next = HOLD;
                end else begin
                    wr_cnt_next = 1'b1;
                end
            end
            HOLD: begin
                state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!ctrl_en) begin
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                end
            end
            default: begin
                bit_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    assign mem_sel_c   = (state_next == SETUP) || (state_next == WRITE) || (state_next == HOLD);
    assign write_sel_c = (state_next == WRITE);

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: scoreboard of expected address/data words
// popped on each chip_en assertion, plus directed timing checks of the write cycle.
module tb_serial_to_parallel;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_en;
    logic        addr_in;
    logic        data_in;
    logic [19:0] addr_out;
    logic [15:0] data_out;
    logic        chip_en;
    logic        write_en;
    logic        out_en;
    logic        lower_byte_en;
    logic        upper_byte_en;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rst_at_edge = 1'b1;

    serial_to_parallel dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_en       (ctrl_en),
        .addr_in       (addr_in),
        .data_in       (data_in),
        .addr_out      (addr_out),
        .data_out      (data_out),
        .chip_en       (chip_en),
        .write_en      (write_en),
        .out_en        (out_en),
        .lower_byte_en (lower_byte_en),
        .upper_byte_en (upper_byte_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_at_edge <= rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic a, input logic d);
        ctrl_en = en;
        addr_in = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [19:0] a, input logic [15:0] d);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, a[i], (i < 16) ? d[4'(i)] : 1'($urandom));
        end
    endtask

    task automatic send_frame(input logic [19:0] a, input logic [15:0] d);
        sb_q.push_back('{addr: a, data: d});
        send_bits(a, d);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Output monitor: pops the scoreboard on each chip_en assertion, audits write pulses
    initial begin : monitor
        logic prev_ce;
        int   wr_low;
        exp_t e;
        prev_ce = 1'b1;
        wr_low  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_at_edge) begin
                prev_ce = 1'b1;
                wr_low  = 0;
            end else begin
                check("out_en_high", 32'(out_en), 32'd1);
                if (prev_ce === 1'b1 && chip_en === 1'b0) begin
                    check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sb_addr", 32'(addr_out), 32'(e.addr));
                        check("sb_data", 32'(data_out), 32'(e.data));
                    end
                end
                if (write_en === 1'b0) begin
                    check("we_needs_ce", 32'(chip_en), 32'd0);
                    wr_low++;
                end
                if (prev_ce === 1'b0 && chip_en === 1'b1) begin
                    check("we_cycles", 32'(wr_low), 32'd2);
                    wr_low = 0;
                end
                prev_ce = chip_en;
            end
        end
    end

    initial begin : main
        logic [19:0] ra;
        logic [15:0] rd;
        logic        b;

        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("rst_ce",   32'(chip_en),       32'd1);
        check("rst_we",   32'(write_en),      32'd1);
        check("rst_oe",   32'(out_en),        32'd1);
        check("rst_lbe",  32'(lower_byte_en), 32'd1);
        check("rst_ube",  32'(upper_byte_en), 32'd1);
        check("rst_addr", 32'(addr_out),      32'd0);
        check("rst_data", 32'(data_out),      32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // 22 enabled edges: ten ones then zeros, checking write-cycle timing edge by edge
        sb_q.push_back('{addr: 20'h003FF, data: 16'h03FF});
        for (int e = 1; e <= 22; e++) begin
            b = (e <= 10);
            step(1'b1, b, b);
            if (e == 19) check("e19_ce", 32'(chip_en), 32'd1);
            if (e == 20) begin
                check("e20_addr", 32'(addr_out),      32'h003FF);
                check("e20_data", 32'(data_out),      32'h03FF);
                check("e20_ce",   32'(chip_en),       32'd0);
                check("e20_we",   32'(write_en),      32'd1);
                check("e20_lbe",  32'(lower_byte_en), 32'd0);
                check("e20_ube",  32'(upper_byte_en), 32'd0);
            end
            if (e >= 21) begin
                check("wr_we", 32'(write_en), 32'd0);
                check("wr_ce", 32'(chip_en),  32'd0);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        check("e23_we", 32'(write_en), 32'd1);
        check("e23_ce", 32'(chip_en),  32'd0);
        check("e23_addr", 32'(addr_out), 32'h003FF);
        step(1'b0, 1'b0, 1'b0);
        check("e24_ce",  32'(chip_en),       32'd1);
        check("e24_we",  32'(write_en),      32'd1);
        check("e24_lbe", 32'(lower_byte_en), 32'd1);
        check("e24_ube", 32'(upper_byte_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("idle_ce", 32'(chip_en), 32'd1);
        end

        // Frame aborted after 12 bits: no memory cycle, outputs keep the last word
        for (int i = 0; i < 12; i++) step(1'b1, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("abort_ce",   32'(chip_en),  32'd1);
            check("abort_we",   32'(write_en), 32'd1);
            check("abort_addr", 32'(addr_out), 32'h003FF);
            check("abort_data", 32'(data_out), 32'h03FF);
        end

        // Alternating 1,0,1,0 on both serial lines
        send_frame(20'h55555, 16'h5555);
        check("alt_addr", 32'(addr_out), 32'h55555);
        check("alt_data", 32'(data_out), 32'h5555);

        for (int k = 0; k < 3; k++) begin
            ra = 20'($urandom);
            rd = 16'($urandom);
            send_frame(ra, rd);
        end

        // Reset asserted during WRITE
        ra = 20'hA5C3F;
        rd = 16'h1E2D;
        sb_q.push_back('{addr: ra, data: rd});
        send_bits(ra, rd);
        step(1'b1, 1'b0, 1'b0);
        check("pre_rst_we", 32'(write_en), 32'd0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        check("wrst_we",   32'(write_en), 32'd1);
        check("wrst_ce",   32'(chip_en),  32'd1);
        check("wrst_addr", 32'(addr_out), 32'd0);
        check("wrst_data", 32'(data_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("post_rst_ce", 32'(chip_en), 32'd1);
        end
        send_frame(20'h0F0F1, 16'hBEEF);
        check("post_rst_addr", 32'(addr_out), 32'h0F0F1);
        check("post_rst_data", 32'(data_out), 32'hBEEF);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
